// File: rtl/screen_ram_writer_if.sv
// CPU write bus into the screen RAM writer: strobe, address and data from the CPU side,
// ready back from the writer.
interface screen_ram_writer_if;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  data;
   logic        ready;

   modport master (
      output we,
      output addr,
      output data,
      input  ready
   );

   modport slave (
      input  we,
      input  addr,
      input  data,
      output ready
   );
endinterface

// File: rtl/screen_ram_writer.sv
// Queues CPU writes aimed at screen memory and drains them into the screen RAM write port;
// also paints every cell with one colour on request. Define VBLANK_ONLY_EN to gate writes to vblank.
module screen_ram_writer #(
   parameter int unsigned FIFO_AW     = 3,
   parameter logic [15:0] SCREEN_BASE = 16'h0200
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   screen_ram_writer_if.slave    cpu,
   input  logic                  clear_start_i,
   input  logic [7:0]            fill_color_i,
   output logic                  clear_busy_o,
   output logic                  clear_done_o,
   input  logic                  vblank_i,
   output logic                  screen_write_en_o,
   output logic [10:0]           screen_write_addr_o,
   output logic [7:0]            screen_write_data_o
);

   localparam int unsigned Depth = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

   typedef enum logic [1:0] {StIdle, StPend, StFill} state_e;

   logic [18:0]        mem_q [Depth];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   cnt_q;
   logic               fifo_full, fifo_empty;
   logic               in_window, push, pop, gate;
   logic [15:0]        offset;

   state_e      state_q, state_d;
   logic [7:0]  color_q, color_d;
   logic [9:0]  fcnt_q, fcnt_d;
   logic        done_q, done_d;
   logic        we_q, we_d;
   logic [10:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        fill_wr;

`ifdef VBLANK_ONLY_EN
   assign gate = vblank_i;
`else
   logic unused_vblank;
   assign unused_vblank = vblank_i;
   assign gate = 1'b1;
`endif

   assign fifo_full  = (cnt_q == DepthCnt);
   assign fifo_empty = (cnt_q == '0);

   // Unsigned wrap makes addresses below the base land far outside the window.
   assign offset    = cpu.addr - SCREEN_BASE;
   assign in_window = (offset < 16'd1024);

   assign cpu.ready    = ~fifo_full & ~clear_busy_o;
   assign clear_busy_o = (state_q != StIdle);
   assign push         = cpu.we & cpu.ready & in_window;
   assign pop          = ~fifo_empty & (state_q != StFill) & gate;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= {cpu.addr[10:0], cpu.data};
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + FIFO_AW'(1);
         if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
         else if (!push && pop) cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      fcnt_d  = fcnt_q;
      done_d  = 1'b0;
      fill_wr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clear_start_i) begin
               color_d = fill_color_i;
               fcnt_d  = '0;
               state_d = StPend;
            end
         end
         // Earlier CPU writes must reach the RAM before the fill starts.
         StPend: begin
            if (fifo_empty && !we_q) state_d = StFill;
         end
         StFill: begin
            if (gate) begin
               fill_wr = 1'b1;
               fcnt_d  = fcnt_q + 10'd1;
               if (fcnt_q == 10'h3FF) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      we_d   = pop | fill_wr;
      addr_d = addr_q;
      data_d = data_q;
      if (fill_wr) begin
         addr_d = SCREEN_BASE[10:0] + {1'b0, fcnt_q};
         data_d = color_q;
      end else if (pop) begin
         {addr_d, data_d} = mem_q[rptr_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         color_q <= '0;
         fcnt_q  <= '0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         fcnt_q  <= fcnt_d;
         done_q  <= done_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign clear_done_o        = done_q;
   assign screen_write_en_o   = we_q;
   assign screen_write_addr_o = addr_q;
   assign screen_write_data_o = data_q;

endmodule

// File: tb/tb_screen_ram_writer.sv
// Scoreboard bench for screen_ram_writer: expected RAM writes are queued at stimulus time
// and popped by a monitor whenever the DUT raises its write enable.
module tb_screen_ram_writer;
   logic        clk = 1'b0;
   logic        reset;
   logic        clear_start;
   logic [7:0]  fill_color;
   logic        clear_busy, clear_done, vblank;
   logic        sw_en;
   logic [10:0] sw_addr;
   logic [7:0]  sw_data;

   screen_ram_writer_if cpu_bus ();

   screen_ram_writer dut (
      .clk_i               (clk),
      .reset_i             (reset),
      .cpu                 (cpu_bus),
      .clear_start_i       (clear_start),
      .fill_color_i        (fill_color),
      .clear_busy_o        (clear_busy),
      .clear_done_o        (clear_done),
      .vblank_i            (vblank),
      .screen_write_en_o   (sw_en),
      .screen_write_addr_o (sw_addr),
      .screen_write_data_o (sw_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;
   int done_exp = 0;
   int fill_seen = 0;
   int vb_mode = 1;  // 0: vblank low, 1: vblank high, 2: random
   logic [18:0] exp_q [$];
   logic [7:0]  dut_screen [1024];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [15:0] a);
      return (a >= 16'h0200) && (a <= 16'h05FF);
   endfunction

   initial begin
      vblank = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (vb_mode == 0)      vblank = 1'b0;
         else if (vb_mode == 1) vblank = 1'b1;
         else                   vblank = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: every RAM write must match the oldest outstanding expectation.
   initial begin
      logic [18:0] e;
      forever begin
         @(negedge clk);
         if (sw_en) begin
            fill_seen++;
            dut_screen[sw_addr - 11'h200] = sw_data;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr=%0h data=%0h, none expected",
                        sw_addr, sw_data);
            end else begin
               e = exp_q.pop_front();
               check("ram_write", {13'd0, sw_addr, sw_data}, {13'd0, e});
            end
         end
         if (clear_done) done_seen++;
      end
   end

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int waited);
      cpu_bus.we   = 1'b1;
      cpu_bus.addr = a;
      cpu_bus.data = d;
      waited = 0;
      @(negedge clk);
      while (!cpu_bus.ready && waited < 500) begin
         waited++;
         @(negedge clk);
      end
      if (!cpu_bus.ready) begin
         checks++;
         errors++;
         $display("FAIL cpu_write_timeout: got ready=0 expected ready=1 addr=%0h", a);
      end else if (in_window(a)) begin
         exp_q.push_back({a[10:0], d});
      end
      @(posedge clk);
      #1;
      cpu_bus.we = 1'b0;
   endtask

   task automatic start_clear(input logic [7:0] color);
      clear_start = 1'b1;
      fill_color  = color;
      @(negedge clk);
      check("clear_accept_idle", {31'd0, clear_busy}, 32'd0);
      for (int i = 0; i < 1024; i++) exp_q.push_back({11'h200 + 11'(i), color});
      done_exp++;
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      fill_color  = 8'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      vb_mode = 1;
      while ((exp_q.size() != 0 || clear_busy) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", exp_q.size(), 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      logic [15:0] a;
      int n;
      reset        = 1'b1;
      clear_start  = 1'b0;
      fill_color   = 8'h00;
      cpu_bus.we   = 1'b0;
      cpu_bus.addr = 16'h0000;
      cpu_bus.data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, cpu_bus.ready}, 32'd1);
      check("rst_busy", {31'd0, clear_busy}, 32'd0);
      check("rst_done", {31'd0, clear_done}, 32'd0);
      check("rst_we", {31'd0, sw_en}, 32'd0);
      check("rst_addr", {21'd0, sw_addr}, 32'd0);
      check("rst_data", {24'd0, sw_data}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single write latency from an idle, empty queue.
      cpu_bus.we   = 1'b1;
      cpu_bus.addr = 16'h0200;
      cpu_bus.data = 8'h05;
      exp_q.push_back({11'h200, 8'h05});
      @(negedge clk);
      check("t1_ready", {31'd0, cpu_bus.ready}, 32'd1);
      @(posedge clk);
      #1;
      cpu_bus.we = 1'b0;
      check("t1_not_yet", {31'd0, sw_en}, 32'd0);
      @(posedge clk);
      #1;
      check("t1_we", {31'd0, sw_en}, 32'd1);
      check("t1_addr", {21'd0, sw_addr}, 32'h200);
      check("t1_data", {24'd0, sw_data}, 32'h05);
      @(posedge clk);
      #1;
      check("t1_single_pulse", {31'd0, sw_en}, 32'd0);

      // Out-of-window writes: accepted immediately, never reach the RAM.
      cpu_write(16'h01FF, 8'h11, w);
      check("t2_ready_01ff", w, 32'd0);
      cpu_write(16'h0600, 8'h22, w);
      check("t2_ready_0600", w, 32'd0);
      cpu_write(16'h8000, 8'h33, w);
      check("t2_ready_8000", w, 32'd0);
      repeat (5) @(posedge clk);
      #1;

`ifdef VBLANK_ONLY_EN
      vb_mode = 0;
      @(posedge clk);
      #2;
      for (int i = 0; i < 8; i++) cpu_write(16'h0300 + 16'(i), 8'(8'h40 + i), w);
      @(negedge clk);
      check("t3_ready_full", {31'd0, cpu_bus.ready}, 32'd0);
      @(posedge clk);
      #1;
      vb_mode = 1;
      cpu_write(16'h0308, 8'h48, w);
      check("t3_ninth_stalled", {31'd0, w > 0}, 32'd1);
      wait_drain();
`endif

      // Randomized traffic with random blanking.
      vb_mode = 2;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 7) a = 16'($urandom_range(16'h0200, 16'h05FF));
         else                          a = 16'($urandom);
         cpu_write(a, 8'($urandom), w);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
      end
      wait_drain();

      // Queued writes then a full clear: CPU writes must come out first.
      vb_mode = 2;
      cpu_write(16'h0210, 8'hA1, w);
      cpu_write(16'h0420, 8'hA2, w);
      cpu_write(16'h05FF, 8'hA3, w);
      start_clear(8'h0E);
      wait_drain();
      check("t4_done_count", done_seen, done_exp);
      check("t4_busy_low", {31'd0, clear_busy}, 32'd0);
      check("t4_ready_high", {31'd0, cpu_bus.ready}, 32'd1);

      // Reset in the middle of a fill.
      vb_mode = 1;
      fill_seen = 0;
      start_clear(8'($urandom_range(16, 255)));
      n = 0;
      while (fill_seen < 500 && n < 3000) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("t5_reached_500", {31'd0, fill_seen >= 500}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_we", {31'd0, sw_en}, 32'd0);
      check("t5_rst_addr", {21'd0, sw_addr}, 32'd0);
      check("t5_rst_data", {24'd0, sw_data}, 32'd0);
      check("t5_rst_busy", {31'd0, clear_busy}, 32'd0);
      check("t5_rst_done", {31'd0, clear_done}, 32'd0);
      check("t5_rst_ready", {31'd0, cpu_bus.ready}, 32'd1);
      exp_q.delete();
      done_exp--;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Fresh clear; a second request with another colour mid-fill is ignored.
      vb_mode = 2;
      fill_seen = 0;
      start_clear(8'h0E);
      n = 0;
      while (fill_seen < 100 && n < 3000) begin
         @(posedge clk);
         #2;
         n++;
      end
      clear_start = 1'b1;
      fill_color  = 8'h01;
      @(negedge clk);
      check("t6_busy_in_fill", {31'd0, clear_busy}, 32'd1);
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      wait_drain();
      check("t6_done_count", done_seen, done_exp);
      n = 0;
      for (int i = 0; i < 1024; i++) if (dut_screen[i] !== 8'h0E) n++;
      check("t6_cells_not_0e", n, 32'd0);
      check("final_ready", {31'd0, cpu_bus.ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
